// File: rtl/cube_scan_driver.sv
// 8x8x8 LED cube layer scanner: shifts each 64-bit layer out serially, latches, then displays it.
// Define FRAME_SNAPSHOT_EN to source a whole frame from a copy taken at layer 0 (tear-free).
`timescale 1ns/1ps
module cube_scan_driver #(
    parameter int CLK_DIV    = 4,
    parameter int LAYER_HOLD = 2000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         scan_en,
    input  logic [511:0] frame_cube_flat,
    output logic         sr_data,
    output logic         sr_clk,
    output logic         sr_latch,
    output logic [7:0]   layer_sel,
    output logic [2:0]   layer_idx,
    output logic         frame_done
);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, DISPLAY} state_t;

    localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [15:0] HOLD_LAST = 16'(LAYER_HOLD - 1);

    state_t      state_q, state_d;
    logic [63:0] shreg_q, shreg_d;
    logic [7:0]  div_q, div_d;
    logic [5:0]  bit_q, bit_d;
    logic        phase_q, phase_d;
    logic [15:0] hold_q, hold_d;
    logic        sr_data_q, sr_data_d;
    logic        sr_clk_q, sr_clk_d;
    logic        sr_latch_q, sr_latch_d;
    logic [7:0]  layer_sel_q, layer_sel_d;
    logic [2:0]  idx_q, idx_d;
    logic        frame_done_q, frame_done_d;

    logic [511:0] src;
    logic [63:0]  layer_bits;

`ifdef FRAME_SNAPSHOT_EN
    logic [511:0] snap_q, snap_d;
    // Layer 0 reads live data: it is the same data being captured this cycle.
    assign src = (idx_q == 3'd0) ? frame_cube_flat : snap_q;
`else
    assign src = frame_cube_flat;
`endif

    assign layer_bits = src[{idx_q, 6'd0} +: 64];

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        div_d        = div_q;
        bit_d        = bit_q;
        phase_d      = phase_q;
        hold_d       = hold_q;
        sr_data_d    = sr_data_q;
        sr_clk_d     = sr_clk_q;
        sr_latch_d   = 1'b0;
        layer_sel_d  = layer_sel_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
`ifdef FRAME_SNAPSHOT_EN
        snap_d       = snap_q;
`endif
        unique case (state_q)
            IDLE: begin
                idx_d       = 3'd0;
                sr_clk_d    = 1'b0;
                layer_sel_d = 8'd0;
                if (scan_en) state_d = LOAD;
            end
            LOAD: begin
                shreg_d   = {layer_bits[62:0], 1'b0};
                sr_data_d = layer_bits[63];
                div_d     = 8'd0;
                bit_d     = 6'd0;
                phase_d   = 1'b0;
                state_d   = SHIFT;
`ifdef FRAME_SNAPSHOT_EN
                if (idx_q == 3'd0) snap_d = frame_cube_flat;
`endif
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = 8'd0;
                    if (!phase_q) begin
                        phase_d  = 1'b1;
                        sr_clk_d = 1'b1;
                    end else begin
                        phase_d  = 1'b0;
                        sr_clk_d = 1'b0;
                        if (bit_q == 6'd63) begin
                            state_d    = LATCH;
                            sr_latch_d = 1'b1;
                        end else begin
                            bit_d     = bit_q + 6'd1;
                            sr_data_d = shreg_q[63];
                            shreg_d   = {shreg_q[62:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            LATCH: begin
                state_d      = DISPLAY;
                layer_sel_d  = 8'd1 << idx_q;
                hold_d       = HOLD_LAST;
                frame_done_d = (HOLD_LAST == 16'd0) && (idx_q == 3'd7);
            end
            DISPLAY: begin
                if (hold_q == 16'd0) begin
                    layer_sel_d = 8'd0;
                    if (scan_en) begin
                        state_d = LOAD;
                        idx_d   = idx_q + 3'd1;
                    end else begin
                        state_d = IDLE;
                        idx_d   = 3'd0;
                    end
                end else begin
                    hold_d       = hold_q - 16'd1;
                    frame_done_d = (hold_q == 16'd1) && (idx_q == 3'd7);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            div_q        <= '0;
            bit_q        <= '0;
            phase_q      <= 1'b0;
            hold_q       <= '0;
            sr_data_q    <= 1'b0;
            sr_clk_q     <= 1'b0;
            sr_latch_q   <= 1'b0;
            layer_sel_q  <= '0;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
`ifdef FRAME_SNAPSHOT_EN
            snap_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            phase_q      <= phase_d;
            hold_q       <= hold_d;
            sr_data_q    <= sr_data_d;
            sr_clk_q     <= sr_clk_d;
            sr_latch_q   <= sr_latch_d;
            layer_sel_q  <= layer_sel_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
`ifdef FRAME_SNAPSHOT_EN
            snap_q       <= snap_d;
`endif
        end
    end

    assign sr_data    = sr_data_q;
    assign sr_clk     = sr_clk_q;
    assign sr_latch   = sr_latch_q;
    assign layer_sel  = layer_sel_q;
    assign layer_idx  = idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cube_scan_driver.sv
// Scoreboard bench for cube_scan_driver: expected layers are queued, a monitor checks each latch.
// Honours FRAME_SNAPSHOT_EN when choosing expectations for the mid-frame image change.
`timescale 1ns/1ps
module tb_cube_scan_driver;

    localparam int CD  = 2;
    localparam int LH  = 16;
    localparam int PER = 274;
    localparam int FRM = 2192;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         scan_en = 1'b0;
    logic [511:0] frame;
    logic         sr_data, sr_clk, sr_latch, frame_done;
    logic [7:0]   layer_sel;
    logic [2:0]   layer_idx;

    cube_scan_driver #(.CLK_DIV(CD), .LAYER_HOLD(LH)) dut (
        .clk(clk), .rst_n(rst_n), .scan_en(scan_en),
        .frame_cube_flat(frame),
        .sr_data(sr_data), .sr_clk(sr_clk), .sr_latch(sr_latch),
        .layer_sel(layer_sel), .layer_idx(layer_idx),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  idx;
        logic [63:0] data;
        int          gap;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   viol = 0;
    int   fd_cnt = 0;
    int   latch_cnt = 0;
    int   fd_t[$];

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endfunction

    function automatic logic [63:0] pat(int gen, int l);
        logic [63:0] p;
        if (l == 0) p = 64'h8000_0000_0000_0001;
        else p = {8{8'(l * 17)}} ^ 64'h0123_4567_89AB_CDEF;
        if (gen == 1) p = ~p;
        return p;
    endfunction

    function automatic logic [511:0] mk(int gen);
        logic [511:0] f;
        for (int l = 0; l < 8; l++) f[l*64 +: 64] = pat(gen, l);
        return f;
    endfunction

    task automatic push(int gen, int l, int gap);
        exp_t e;
        e.idx  = 3'(l);
        e.data = pat(gen, l);
        e.gap  = gap;
        q.push_back(e);
    endtask

    // Monitor: reconstructs each shifted word and checks it when the latch pulses.
    initial begin
        logic        prev_clk, prev_fd;
        logic [63:0] cap;
        logic [7:0]  exp_sel, run_sel;
        int          edges, run_len, last_latch;
        exp_t        e;
        prev_clk = 0; prev_fd = 0; cap = 0; edges = 0;
        run_len = 0; last_latch = 0; exp_sel = 0; run_sel = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_clk = 0; prev_fd = 0; cap = 0; edges = 0; run_len = 0;
            end else begin
                if ((sr_clk !== prev_clk || sr_latch) && layer_sel != 8'd0) viol++;
                if (sr_clk && !prev_clk) begin
                    cap = {cap[62:0], sr_data};
                    edges++;
                end
                if (sr_latch) begin
                    latch_cnt++;
                    if (q.size() == 0) begin
                        chk("unexpected latch", 64'd1, 64'd0);
                    end else begin
                        e = q.pop_front();
                        chk("shift data", cap, e.data);
                        chk("sr_clk edges", 64'(edges), 64'd64);
                        chk("latch layer_idx", 64'(layer_idx), 64'(e.idx));
                        if (e.gap != 0) chk("layer period", 64'(cyc - last_latch), 64'(e.gap));
                        exp_sel = 8'd1 << e.idx;
                    end
                    last_latch = cyc;
                    cap = 0;
                    edges = 0;
                end
                if (layer_sel != 8'd0) begin
                    if (run_len == 0) run_sel = layer_sel;
                    else if (layer_sel != run_sel) viol++;
                    run_len++;
                end else if (run_len != 0) begin
                    chk("display length", 64'(run_len), 64'(LH));
                    chk("display layer_sel", 64'(run_sel), 64'(exp_sel));
                    run_len = 0;
                end
                if (frame_done) begin
                    fd_cnt++;
                    fd_t.push_back(cyc);
                    chk("frame_done layer_sel", 64'(layer_sel), 64'h80);
                    if (prev_fd) viol++;
                end
                prev_clk = sr_clk;
                prev_fd  = frame_done;
            end
        end
    end

    task automatic wait_fd(int n);
        for (int k = 0; k < 6000 && fd_cnt < n; k++) @(negedge clk);
        if (fd_cnt < n) chk("timeout frame_done", 64'd0, 64'd1);
    endtask

    task automatic wait_shift(int l);
        for (int k = 0; k < 3000 && !(int'(layer_idx) == l && sr_clk); k++) @(negedge clk);
        if (!(int'(layer_idx) == l && sr_clk)) chk("timeout shift", 64'd0, 64'd1);
    endtask

    task automatic wait_sel(bit nz);
        for (int k = 0; k < 3000 && ((layer_sel != 8'd0) != nz); k++) @(negedge clk);
        if ((layer_sel != 8'd0) != nz) chk("timeout layer_sel", 64'd0, 64'd1);
    endtask

    initial begin
        int lc;
        int snap;
`ifdef FRAME_SNAPSHOT_EN
        snap = 1;
`else
        snap = 0;
`endif
        frame = mk(0);
        repeat (3) @(negedge clk);
        chk("reset outputs",
            64'({sr_data, sr_clk, sr_latch, layer_sel, layer_idx, frame_done}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle layer_sel", 64'(layer_sel), 64'd0);

        for (int l = 0; l < 8; l++) push(0, l, (l == 0) ? 0 : PER);
        for (int l = 0; l < 8; l++) push((l > 3 && snap == 0) ? 1 : 0, l, PER);
        for (int l = 0; l < 3; l++) push(1, l, PER);
        scan_en = 1'b1;

        wait_fd(1);
        wait_shift(3);
        frame = mk(1);
        wait_fd(2);
        wait_shift(2);
        scan_en = 1'b0;
        wait_sel(1'b1);
        wait_sel(1'b0);
        lc = latch_cnt;
        repeat (20) @(negedge clk);
        chk("stop layer_idx", 64'(layer_idx), 64'd0);
        chk("stop layer_sel", 64'(layer_sel), 64'd0);
        chk("stop sr_clk", 64'(sr_clk), 64'd0);
        chk("stop no latch", 64'(latch_cnt), 64'(lc));
        chk("frame_done count", 64'(fd_cnt), 64'd2);
        if (fd_t.size() >= 2) chk("frame_done interval", 64'(fd_t[1] - fd_t[0]), 64'(FRM));

        push(1, 0, 0);
        scan_en = 1'b1;
        wait_sel(1'b1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("async reset outputs",
               64'({sr_data, sr_clk, sr_latch, layer_sel, layer_idx, frame_done}), 64'd0);
        push(1, 0, 0);
        push(1, 1, PER);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_shift(1);
        scan_en = 1'b0;
        wait_sel(1'b1);
        wait_sel(1'b0);
        repeat (5) @(negedge clk);
        chk("queue drained", 64'(q.size()), 64'd0);
        chk("blanking/pulse violations", 64'(viol), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cube_scan_driver.md
CUBE_SCAN_DRIVER -- requirements
Module: cube_scan_driver

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per sr_clk half-period; legal range 1..255.
REQ-002 Parameter LAYER_HOLD, default 2000: clk cycles each layer stays lit; legal range 1..65535.
REQ-003 clk  input  1  single system clock; all logic is on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 scan_en  input  1  high enables scanning; low stops it at the next layer boundary.
REQ-006 frame_cube_flat  input  512  cube image; layer L is bits [L*64+63 : L*64], bit 1 = LED on.
REQ-007 sr_data  output  1  serial column data to the external shift-register chain.
REQ-008 sr_clk  output  1  shift clock; data is sampled externally on its rising edge.
REQ-009 sr_latch  output  1  one-cycle storage-register latch pulse.
REQ-010 layer_sel  output  8  one-hot layer enable, active-high; bit L drives layer L.
REQ-011 layer_idx  output  3  index of the layer currently being loaded, shifted or displayed.
REQ-012 frame_done  output  1  one-cycle pulse when layer 7 display ends.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, SHIFT, LATCH and DISPLAY.
REQ-014 IDLE SHALL go to LOAD with layer_idx=0 on the first cycle scan_en=1.
REQ-015 LOAD (1 cycle) SHALL copy the 64 bits of layer layer_idx into the shift register.
REQ-016 SHIFT SHALL send 64 bits MSB first (bit layer_idx*64+63 first).
REQ-017 SHIFT timing per bit: sr_data valid with sr_clk low for CLK_DIV cycles, then sr_clk high for CLK_DIV cycles; 128*CLK_DIV cycles in total.
REQ-018 sr_clk SHALL be 0 outside SHIFT; sr_data SHALL hold its last value outside SHIFT.
REQ-019 LATCH (1 cycle) SHALL assert sr_latch=1; sr_latch SHALL be 0 in every other state.
REQ-020 layer_sel SHALL be 0 in LOAD, SHIFT and LATCH (ghost blanking).
REQ-021 DISPLAY SHALL drive layer_sel = 1<<layer_idx for exactly LAYER_HOLD cycles.
REQ-022 Layer period SHALL be 2 + 128*CLK_DIV + LAYER_HOLD cycles.
REQ-023 At DISPLAY end with scan_en=1, layer_idx SHALL increment modulo 8 (7 wraps to 0) and the FSM SHALL go to LOAD.
REQ-024 frame_done SHALL pulse for 1 cycle on the last DISPLAY cycle of layer 7.
REQ-025 At DISPLAY end with scan_en=0, the FSM SHALL go to IDLE and layer_idx SHALL return to 0.
REQ-026 scan_en=0 during LOAD, SHIFT or LATCH SHALL NOT abort the layer; the layer completes its DISPLAY first.
REQ-027 All counters SHALL be sized for their parameter maxima and SHALL NOT wrap inside a state.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE and clear all counters and the snapshot register.
REQ-029 While rst_n=0, every output SHALL be 0 (sr_data, sr_clk, sr_latch, layer_sel, layer_idx, frame_done).
REQ-030 Reset mid-operation SHALL blank layer_sel asynchronously; after release, scanning restarts from layer 0.

Configuration
REQ-031 Macro FRAME_SNAPSHOT_EN.
- Defined: LOAD with layer_idx=0 SHALL capture all 512 input bits into a snapshot register, and all eight layers of the frame SHALL be sourced from it (tear-free).
- Undefined: no snapshot register; each LOAD SHALL read frame_cube_flat live.

Verification
REQ-032 Assert rst_n=0 mid-DISPLAY -> all outputs 0 in the same cycle; release with scan_en=1 -> LOAD of layer 0.
REQ-033 CLK_DIV=2, LAYER_HOLD=16, layer0=64'h8000_0000_0000_0001 -> sr_data=1 on bits 1 and 64 and 0 otherwise; 64 sr_clk rising edges; one sr_latch pulse; layer_sel=8'h01 for 16 cycles; layer period 274 cycles.
REQ-034 Free run, same parameters -> layer_sel sequence 01,02,04,...,80; frame_done pulses once every 2192 cycles; the sequence wraps back to 01.
REQ-035 Change frame_cube_flat during layer 3 SHIFT -> with FRAME_SNAPSHOT_EN, layers 3-7 shift the old data and the new frame appears from layer 0; without it, layer 4 shifts the new data.
REQ-036 Drop scan_en during layer 2 SHIFT -> layer 2 completes its 16-cycle DISPLAY, then IDLE with layer_sel=0 and layer_idx=0; re-raise scan_en -> restart at layer 0.
REQ-037 Check layer_sel==0 on every cycle where sr_clk toggles or sr_latch=1 -> never violated.
